// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer and its button debouncer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_ASSERT,
        SEQ_RELEASE,
        SEQ_RUN
    } seq_state_t;

    typedef enum logic [1:0] {
        DEB_IDLE,
        DEB_HELD,
        DEB_LOCKOUT
    } deb_state_t;

    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_USER = 1;
    localparam int CAUSE_SW   = 2;
    localparam int CAUSE_WDT  = 3;

    // Counter width able to hold the larger of two compare values.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset-source inputs, per-domain reset outputs and FSM debug state of the sequencer.
interface reset_sequencer_if #(
    parameter int CHANNEL_COUNT = 4
);
    import reset_seq_pkg::*;

    logic                     user_rst_n;
    logic                     sw_rst_req;
    logic                     wdt_expire;
    logic                     cause_clear;
    logic [CHANNEL_COUNT-1:0] channel_rst;
    logic                     all_released;
    logic [3:0]               rst_cause;
    seq_state_t               seq_state;
    deb_state_t               deb_state;

    modport master (
        output user_rst_n, sw_rst_req, wdt_expire, cause_clear,
        input  channel_rst, all_released, rst_cause, seq_state, deb_state
    );

    modport slave (
        input  user_rst_n, sw_rst_req, wdt_expire, cause_clear,
        output channel_rst, all_released, rst_cause, seq_state, deb_state
    );

endinterface

// File: rtl/reset_button_debouncer.sv
// Turns a synchronised active-low button into one press pulse per press, with
// a minimum-low validation window and a post-release lockout.
module reset_button_debouncer
    import reset_seq_pkg::*;
#(
    parameter int Press_Validation_Wait_Cycles = 10,
    parameter int Release_Lockout_Cycles       = 20
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic       clk_en,
    input  logic       user_rst_n,
    output logic       press_pulse,
    output deb_state_t deb_state
);
    localparam int CNT_W = cnt_width(Press_Validation_Wait_Cycles, Release_Lockout_Cycles);

    deb_state_t       state_q;
    logic [CNT_W-1:0] count_q;
    logic             press_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= DEB_IDLE;
            count_q <= '0;
            press_q <= 1'b0;
        end else if (clk_en) begin
            press_q <= 1'b0;
            case (state_q)
                DEB_IDLE: begin
                    if (user_rst_n) begin
                        count_q <= '0;
                    end else if (count_q == CNT_W'(Press_Validation_Wait_Cycles - 1)) begin
                        press_q <= 1'b1;
                        state_q <= DEB_HELD;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                DEB_HELD: begin
                    // The releasing edge is the first clean high cycle of the lockout.
                    if (user_rst_n) begin
                        if (Release_Lockout_Cycles == 1) begin
                            state_q <= DEB_IDLE;
                            count_q <= '0;
                        end else begin
                            state_q <= DEB_LOCKOUT;
                            count_q <= CNT_W'(1);
                        end
                    end
                end
                DEB_LOCKOUT: begin
                    if (!user_rst_n) begin
                        count_q <= '0;
                    end else if (count_q == CNT_W'(Release_Lockout_Cycles - 1)) begin
                        state_q <= DEB_IDLE;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= DEB_IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign press_pulse = press_q;
    assign deb_state   = state_q;

endmodule

// File: rtl/reset_sequencer.sv
// Merges POR, button, software and watchdog resets into one event, asserts all
// domains together and releases them one at a time from index 0 upwards.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int Channel_Count                = 4,
    parameter int Pulse_Length                 = 4,
    parameter int Stage_Delay_Cycles           = 8,
    parameter int Press_Validation_Wait_Cycles = 10,
    parameter int Release_Lockout_Cycles       = 20
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             clk_en,
    reset_sequencer_if.slave bus
);
    localparam int CNT_W = cnt_width(Pulse_Length, Stage_Delay_Cycles);

    seq_state_t               state_q;
    logic [CNT_W-1:0]         count_q;
    logic [Channel_Count-1:0] channel_rst_q;
    logic [Channel_Count-1:0] chan_shift;
    logic                     all_released_q;
    logic [3:0]               cause_q;
    logic [3:0]               cause_d;
    logic                     press;
    logic                     trigger;

    reset_button_debouncer #(
        .Press_Validation_Wait_Cycles(Press_Validation_Wait_Cycles),
        .Release_Lockout_Cycles      (Release_Lockout_Cycles)
    ) u_debouncer (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .clk_en     (clk_en),
        .user_rst_n (bus.user_rst_n),
        .press_pulse(press),
        .deb_state  (bus.deb_state)
    );

    assign trigger = press | bus.sw_rst_req | bus.wdt_expire;

    // Domains release bottom-up, so dropping the lowest asserted bit is a left shift.
    assign chan_shift = channel_rst_q << 1;

    always_comb begin
        cause_d = cause_q;
        if (bus.cause_clear) cause_d[CAUSE_WDT:CAUSE_USER] = '0;
        if (press)           cause_d[CAUSE_USER] = 1'b1;
        if (bus.sw_rst_req)  cause_d[CAUSE_SW]   = 1'b1;
        if (bus.wdt_expire)  cause_d[CAUSE_WDT]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q        <= SEQ_ASSERT;
            count_q        <= '0;
            channel_rst_q  <= '1;
            all_released_q <= 1'b0;
            cause_q        <= 4'(1 << CAUSE_POR);
        end else if (clk_en) begin
            cause_q <= cause_d;
            if (trigger) begin
                state_q        <= SEQ_ASSERT;
                count_q        <= '0;
                channel_rst_q  <= '1;
                all_released_q <= 1'b0;
            end else begin
                case (state_q)
                    SEQ_ASSERT, SEQ_RELEASE: begin
                        if ((state_q == SEQ_ASSERT && count_q == CNT_W'(Pulse_Length - 1)) ||
                            (state_q == SEQ_RELEASE && count_q == CNT_W'(Stage_Delay_Cycles - 1))) begin
                            count_q       <= '0;
                            channel_rst_q <= chan_shift;
                            if (chan_shift == '0) begin
                                state_q        <= SEQ_RUN;
                                all_released_q <= 1'b1;
                            end else begin
                                state_q <= SEQ_RELEASE;
                            end
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    SEQ_RUN: begin
                        count_q <= '0;
                    end
                    default: begin
                        state_q <= SEQ_ASSERT;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.channel_rst  = channel_rst_q;
    assign bus.all_released = all_released_q;
    assign bus.rst_cause    = cause_q;
    assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a cycle model predicts every output
// per clock, queues the prediction and compares it once the edge has happened.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int CC    = 4;
    localparam int PL    = 4;
    localparam int SD    = 8;
    localparam int PV    = 10;
    localparam int RL    = 20;
    localparam int EXP_W = CC + 1 + 4;

    logic clk = 1'b0;
    logic sync_rst;
    logic clk_en;

    reset_sequencer_if #(.CHANNEL_COUNT(CC)) bus ();

    reset_sequencer #(
        .Channel_Count               (CC),
        .Pulse_Length                (PL),
        .Stage_Delay_Cycles          (SD),
        .Press_Validation_Wait_Cycles(PV),
        .Release_Lockout_Cycles      (RL)
    ) dut (
        .clk     (clk),
        .sync_rst(sync_rst),
        .clk_en  (clk_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Model state: clk_en edges since the last reset event, cause bits, button history.
    int       n_edges = 0;
    logic [3:0] m_cause = 4'b0001;
    int       low_run = 0;
    int       high_run = 0;
    bit       armed = 1'b1;
    bit       press_pend = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] expected();
        logic [CC-1:0] chan;
        logic          all_rel;
        for (int k = 0; k < CC; k++) chan[k] = (n_edges < PL + k * SD);
        all_rel = (n_edges >= PL + (CC - 1) * SD);
        return {all_rel, chan, m_cause};
    endfunction

    // Advance the model over the coming edge using the inputs now on the pins.
    task automatic model_edge();
        bit trig_user;
        if (sync_rst) begin
            n_edges    = 0;
            m_cause    = 4'b0001;
            low_run    = 0;
            high_run   = 0;
            armed      = 1'b1;
            press_pend = 1'b0;
        end else if (clk_en) begin
            trig_user  = press_pend;
            press_pend = 1'b0;
            if (!bus.user_rst_n) begin
                low_run++;
                high_run = 0;
                if (armed && low_run == PV) begin
                    press_pend = 1'b1;
                    armed      = 1'b0;
                end
            end else begin
                high_run++;
                low_run = 0;
                if (!armed && high_run == RL) armed = 1'b1;
            end
            if (bus.cause_clear) m_cause[3:1] = 3'b000;
            if (trig_user)      m_cause[1] = 1'b1;
            if (bus.sw_rst_req) m_cause[2] = 1'b1;
            if (bus.wdt_expire) m_cause[3] = 1'b1;
            if (trig_user || bus.sw_rst_req || bus.wdt_expire) n_edges = 0;
            else if (n_edges < 100000) n_edges++;
        end
        exp_q.push_back(expected());
    endtask

    task automatic drive_cycle();
        logic [EXP_W-1:0] want;
        model_edge();
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_val("channel_rst", 32'(bus.channel_rst), 32'(want[CC+4:5] & 0) | 32'(want[CC+3:4]));
        check_val("all_released", 32'(bus.all_released), 32'(want[CC+4]));
        check_val("rst_cause", 32'(bus.rst_cause), 32'(want[3:0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic button_low(input int n);
        bus.user_rst_n = 1'b0;
        run(n);
        bus.user_rst_n = 1'b1;
    endtask

    initial begin
        sync_rst        = 1'b1;
        clk_en          = 1'b0;
        bus.user_rst_n  = 1'b1;
        bus.sw_rst_req  = 1'b0;
        bus.wdt_expire  = 1'b0;
        bus.cause_clear = 1'b0;

        // Power-up: reset acts with clk_en low too, then a full staged release.
        run(4);
        clk_en = 1'b1;
        run(4);
        check_val("por_state", 32'(bus.channel_rst), 32'h0000000f);
        sync_rst = 1'b0;
        run(40);
        check_val("por_cause", 32'(bus.rst_cause), 32'h1);
        check_val("por_all_released", 32'(bus.all_released), 32'h1);

        // Button glitch of 9 cycles is ignored; a 10-cycle press restarts everything.
        button_low(9);
        run(30);
        bus.user_rst_n = 1'b0;
        run(10);
        bus.user_rst_n = 1'b1;
        run(1);
        check_val("press_assert", 32'(bus.channel_rst), 32'h0000000f);
        run(45);
        check_val("press_cause", 32'(bus.rst_cause), 32'h3);

        // Lockout: long hold, bounce during lockout, clean re-press.
        button_low(40);
        run(5);
        button_low(12);
        run(25);
        button_low(10);
        run(40);

        // Software request mid-release while channel_rst is 4'hC.
        bus.sw_rst_req = 1'b1;
        run(1);
        bus.sw_rst_req = 1'b0;
        run(14);
        check_val("mid_seq_chan", 32'(bus.channel_rst), 32'h0000000c);
        bus.sw_rst_req = 1'b1;
        run(1);
        bus.sw_rst_req = 1'b0;
        check_val("restart_chan", 32'(bus.channel_rst), 32'h0000000f);
        check_val("sw_cause_bit", 32'(bus.rst_cause[CAUSE_SW]), 32'h1);
        run(40);

        // Simultaneous watchdog, software request and cause clear.
        bus.wdt_expire  = 1'b1;
        bus.sw_rst_req  = 1'b1;
        bus.cause_clear = 1'b1;
        run(1);
        bus.wdt_expire  = 1'b0;
        bus.sw_rst_req  = 1'b0;
        bus.cause_clear = 1'b0;
        check_val("simul_cause", 32'(bus.rst_cause), 32'hd);
        run(40);

        // Throttled clock enable; a watchdog pulse on an idle cycle is ignored.
        bus.sw_rst_req = 1'b1;
        run(1);
        bus.sw_rst_req = 1'b0;
        for (int i = 0; i < 72; i++) begin
            clk_en = (i % 2 == 1);
            bus.wdt_expire = (i == 20);
            run(1);
        end
        bus.wdt_expire = 1'b0;
        clk_en = 1'b1;
        run(2);
        check_val("throttle_done", 32'(bus.all_released), 32'h1);

        // Cause clear only acts on an enabled cycle and never drops the POR bit.
        clk_en = 1'b0;
        bus.cause_clear = 1'b1;
        run(1);
        clk_en = 1'b1;
        run(1);
        bus.cause_clear = 1'b0;
        check_val("clear_cause", 32'(bus.rst_cause), 32'h1);
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
